// File: rtl/uart_axi_bridge_if.sv
// AXI4-Lite bus between the bridge (master) and an AXI UART Lite core (slave).
interface uart_axi_bridge_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_axi_bridge.sv
// Buffers upstream bytes and feeds an AXI UART Lite core, checking STAT before each transfer.
// Define UART_RX_EN to enable the receive path (STAT polling, RX reads, rx_* stream port).
module uart_axi_bridge #(
    parameter int TX_DEPTH    = 16,
    parameter int POLL_CYCLES = 1024,
    parameter int ADDR_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    uart_axi_bridge_if.master         axi,
    output logic                      err,
    output logic [$clog2(TX_DEPTH):0] tx_level
);
    localparam int LW = $clog2(TX_DEPTH);
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(32'h0);
    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(32'h4);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(32'h8);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'hC);
`ifdef UART_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RADDR, S_RDATA, S_DECIDE, S_WADDR, S_WRESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic [7:0]        wdata_q, wdata_d, rx_data_q, rx_data_d;
    logic              rd_rx_q, rd_rx_d, stat_rx_q, stat_rx_d, stat_full_q, stat_full_d;
    logic              rx_valid_q, rx_valid_d, rx_prio_q, rx_prio_d, err_q, err_d;

    logic [7:0]        mem [TX_DEPTH];
    logic [LW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW:0]       count_q;
    logic              full, empty, push, pop;
    logic              go_stat, poll_hit, rx_allowed;
    logic              unused_rdata;

    assign full       = (count_q == (LW+1)'(TX_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = tx_valid && !full;
    assign go_stat    = (state_q == S_IDLE) && (!empty || push || poll_hit);
    assign rx_allowed = RX_EN && stat_rx_q && !rx_valid_q;

`ifdef UART_RX_EN
    logic [PW-1:0] poll_q, poll_d;

    assign poll_hit = (poll_q == PW'(POLL_CYCLES - 1));

    always_comb begin
        poll_d = poll_q;
        if (go_stat)
            poll_d = '0;
        else if (state_q == S_IDLE)
            poll_d = poll_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) poll_q <= '0;
        else        poll_q <= poll_d;
    end
`else
    assign poll_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rd_rx_d     = rd_rx_q;
        stat_rx_d   = stat_rx_q;
        stat_full_d = stat_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_prio_d   = rx_prio_q;
        err_d       = err_q;
        pop         = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if ((axi.bvalid && bready_q && axi.bresp != 2'b00) ||
            (axi.rvalid && rready_q && axi.rresp != 2'b00))
            err_d = 1'b1;

        case (state_q)
            S_INIT: begin
                awaddr_d  = A_CTRL;
                wdata_d   = 8'h03;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = S_WADDR;
            end
            S_IDLE: begin
                if (go_stat) begin
                    araddr_d  = A_STAT;
                    arvalid_d = 1'b1;
                    rd_rx_d   = 1'b0;
                    state_d   = S_RADDR;
                end
            end
            S_RADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (axi.rvalid && rready_q) begin
                    rready_d = 1'b0;
                    if (rd_rx_q) begin
                        rx_data_d  = axi.rdata[7:0];
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        stat_rx_d   = axi.rdata[0];
                        stat_full_d = axi.rdata[3];
                        state_d     = S_DECIDE;
                    end
                end
            end
            S_DECIDE: begin
                // rx_prio alternates the preferred direction so neither side starves
                if (rx_allowed && (rx_prio_q || empty || stat_full_q)) begin
                    araddr_d  = A_RX;
                    arvalid_d = 1'b1;
                    rd_rx_d   = 1'b1;
                    rx_prio_d = !rx_prio_q;
                    state_d   = S_RADDR;
                end else if (!empty && !stat_full_q) begin
                    pop       = 1'b1;
                    wdata_d   = mem[rd_ptr_q];
                    awaddr_d  = A_TX;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    rx_prio_d = !rx_prio_q;
                    state_d   = S_WADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WADDR: begin
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rd_rx_q     <= 1'b0;
            stat_rx_q   <= 1'b0;
            stat_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_prio_q   <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rd_rx_q     <= rd_rx_d;
            stat_rx_q   <= stat_rx_d;
            stat_full_q <= stat_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_prio_q   <= rx_prio_d;
            err_q       <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + LW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
            count_q     <= count_q + (LW+1)'(push) - (LW+1)'(pop);
        end
    end

    assign unused_rdata = ^{axi.rdata[31:8], axi.rdata[2:1]};

    assign tx_ready    = !full;
    assign tx_level    = count_q;
    assign err         = err_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = RX_EN ? rx_valid_q : 1'b0;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = {24'h0, wdata_q};
    assign axi.wstrb   = 4'b0001;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
endmodule

// File: tb/tb_uart_axi_bridge.sv
// Bench for uart_axi_bridge: UART Lite slave model, byte scoreboard, vector table and corner sequences.
module tb_uart_axi_bridge;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       err;
    logic [4:0] tx_level;

    uart_axi_bridge_if #(.ADDR_W(4)) bus ();

    uart_axi_bridge #(.TX_DEPTH(16), .POLL_CYCLES(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .axi(bus), .err(err), .tx_level(tx_level)
    );

    always #5 clk = ~clk;

    // slave configuration (written by the test) and observation logs (written by the slave)
    logic       hold_aw, rand_rdy;
    logic [1:0] bresp_cfg;
    logic [7:0] stat_val, rx_reg;
    int         full_until;
    int         wr_cnt = 0, stat_reads = 0, rx_reads = 0, viol = 0, strb_bad = 0;
    logic [3:0] wlog_addr [512];
    logic [7:0] wlog_data [512];
    logic       aw_got, w_got, last_full;
    logic [3:0] aw_a;
    logic [7:0] w_d;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.awready <= 1'b0; bus.wready <= 1'b0; bus.arready <= 1'b0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; last_full <= 1'b0; aw_a <= '0; w_d <= '0;
        end else begin
            bus.awready <= !hold_aw && !aw_got && (!rand_rdy || ($urandom % 2) == 1);
            bus.wready  <= !w_got && (!rand_rdy || ($urandom % 2) == 1);
            bus.arready <= !rand_rdy || ($urandom % 2) == 1;
            if (bus.awvalid && bus.awready) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
            if (bus.wvalid && bus.wready) begin
                w_got <= 1'b1; w_d <= bus.wdata[7:0];
                if (bus.wstrb != 4'b0001 || bus.wdata[31:8] != 24'h0) strb_bad <= strb_bad + 1;
            end
            if (aw_got && w_got) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                bus.bvalid <= 1'b1;
                bus.bresp  <= (aw_a == 4'h4) ? bresp_cfg : 2'b00;
                wlog_addr[wr_cnt] <= aw_a; wlog_data[wr_cnt] <= w_d; wr_cnt <= wr_cnt + 1;
                if (aw_a == 4'h4 && last_full) viol <= viol + 1;
            end else if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1; bus.rresp <= 2'b00;
                if (bus.araddr == 4'h8) begin
                    stat_reads <= stat_reads + 1;
                    if (stat_reads < full_until) begin
                        bus.rdata <= 32'h8; last_full <= 1'b1;
                    end else begin
                        bus.rdata <= {24'h0, stat_val}; last_full <= stat_val[3];
                    end
                end else if (bus.araddr == 4'h0) begin
                    rx_reads <= rx_reads + 1; bus.rdata <= {24'h0, rx_reg};
                end else begin
                    bus.rdata <= '0;
                end
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    typedef struct {
        int         nbytes;
        int         full_polls;
        logic [1:0] bresp;
        bit         rnd;
        bit         exp_err;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        total++; bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_wr(input int target, input int budget, input string name);
        int n = 0;
        while (wr_cnt < target && n < budget) begin @(negedge clk); n++; end
        if (wr_cnt < target) timeout(name);
    endtask

    task automatic push_byte(input logic [7:0] d, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            tx_data = d; tx_valid = 1'b1; ok = tx_ready;
            @(posedge clk);
            n++;
        end
    endtask

    task automatic push_exp(input logic [7:0] d);
        bit ok;
        push_byte(d, 400, ok);
        if (ok) exp_q.push_back(d);
        else timeout("push");
    endtask

    task automatic stop_tx();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic check_writes(input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("wr%0d addr", i), {28'h0, wlog_addr[base+i]}, 32'h4);
            check($sformatf("wr%0d data", i), {24'h0, wlog_data[base+i]}, {24'h0, exp_q[i]});
        end
    endtask

    task automatic reset_dut();
        int base;
        @(negedge clk);
        rst_n = 1'b0; tx_valid = 1'b0; rand_rdy = 1'b0; hold_aw = 1'b0; bresp_cfg = 2'b00;
        @(posedge clk); @(negedge clk);
        check("rst awvalid", {31'h0, bus.awvalid}, 0);
        check("rst err", {31'h0, err}, 0);
        check("rst level", {27'h0, tx_level}, 0);
        rst_n = 1'b1;
        base = wr_cnt;
        wait_wr(base + 1, 60, "init write");
        check("init addr", {28'h0, wlog_addr[base]}, 32'hC);
        check("init data", {24'h0, wlog_data[base]}, 32'h03);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int  base, s0, v0, r0, n, idx, acc;
        bit  ok;
        logic [7:0] d;
        logic [7:0] fill [20];

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        hold_aw = 1'b0; rand_rdy = 1'b0; bresp_cfg = 2'b00;
        stat_val = 8'h04; rx_reg = 8'h5A; full_until = 0;

        vecs[0] = '{3,  0, 2'b00, 1'b1, 1'b0};
        vecs[1] = '{20, 0, 2'b00, 1'b1, 1'b0};
        vecs[2] = '{4,  3, 2'b00, 1'b1, 1'b0};
        vecs[3] = '{5,  0, 2'b10, 1'b1, 1'b1};
        vecs[4] = '{8,  2, 2'b11, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset arvalid", {31'h0, bus.arvalid}, 0);
        check("reset bready",  {31'h0, bus.bready}, 0);
        check("reset rready",  {31'h0, bus.rready}, 0);
        check("reset awaddr",  {28'h0, bus.awaddr}, 0);
        check("reset wdata",   bus.wdata, 0);
        check("reset rx_valid", {31'h0, rx_valid}, 0);
        reset_dut();

`ifndef UART_RX_EN
        base = wr_cnt; s0 = stat_reads;
        repeat (200) @(negedge clk);
        check("idle writes", wr_cnt - base, 0);
        check("idle stat reads", stat_reads - s0, 0);
`endif
        check("idle err", {31'h0, err}, 0);

        // three back-to-back bytes, ideal slave
        exp_q.delete(); base = wr_cnt; s0 = stat_reads;
        push_exp(8'h41); push_exp(8'h42); push_exp(8'h43);
        stop_tx();
        check("level after 3 pushes", {27'h0, tx_level}, 3);
        wait_wr(base + 3, 300, "three bytes");
        check_writes(base);
        repeat (5) @(negedge clk);
        check("level drained", {27'h0, tx_level}, 0);
`ifndef UART_RX_EN
        check("three stat reads", stat_reads - s0, 3);
`endif

        // table of randomized runs
        for (int v = 0; v < 5; v++) begin
            reset_dut();
            rand_rdy = vecs[v].rnd; bresp_cfg = vecs[v].bresp;
            full_until = stat_reads + vecs[v].full_polls;
            exp_q.delete(); base = wr_cnt; v0 = viol;
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                d = 8'($urandom);
                push_exp(d);
            end
            stop_tx();
            wait_wr(base + exp_q.size(), 4000, $sformatf("vec%0d writes", v));
            check_writes(base);
            repeat (12) @(negedge clk);
            check($sformatf("vec%0d level", v), {27'h0, tx_level}, 0);
            check($sformatf("vec%0d err", v), {31'h0, err}, {31'h0, vecs[v].exp_err});
            check($sformatf("vec%0d full respected", v), viol - v0, 0);
        end

        // fill past depth while the core reports tx_full
        reset_dut();
        full_until = stat_reads + 100000;
        exp_q.delete(); base = wr_cnt; idx = 0;
        for (int i = 0; i < 20; i++) fill[i] = 8'($urandom);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tx_valid = (idx < 20);
            tx_data  = (idx < 20) ? fill[idx] : 8'h00;
            acc = (tx_valid && tx_ready) ? 1 : 0;
            @(posedge clk);
            if (acc == 1) begin exp_q.push_back(fill[idx]); idx++; end
        end
        stop_tx();
        check("fill accepted", idx, 16);
        check("fill level", {27'h0, tx_level}, 16);
        check("fill tx_ready", {31'h0, tx_ready}, 0);
        check("fill no tx writes", wr_cnt - base, 0);
        full_until = stat_reads;
        while (idx < 20) begin
            push_byte(fill[idx], 400, ok);
            if (!ok) begin timeout("fill push"); break; end
            exp_q.push_back(fill[idx]); idx++;
        end
        stop_tx();
        wait_wr(base + 20, 2000, "fill writes");
        check_writes(base);

        // tx_full for five polls, then clear
        reset_dut();
        full_until = stat_reads + 5; s0 = stat_reads; v0 = viol;
        exp_q.delete(); base = wr_cnt;
        push_exp(8'h55);
        stop_tx();
        wait_wr(base + 1, 500, "full then clear");
        check_writes(base);
        check("polls before write", {31'h0, (stat_reads - s0) >= 6}, 1);
        check("no write while full", viol - v0, 0);

        // sticky err, then reset in the middle of an AW
        reset_dut();
        bresp_cfg = 2'b10;
        base = wr_cnt; exp_q.delete();
        push_exp(8'hA5); stop_tx();
        wait_wr(base + 1, 300, "slverr write");
        repeat (10) @(negedge clk);
        check("err set", {31'h0, err}, 1);
        bresp_cfg = 2'b00;
        push_exp(8'h3C); stop_tx();
        wait_wr(base + 2, 300, "okay write");
        repeat (10) @(negedge clk);
        check("err sticky", {31'h0, err}, 1);
        hold_aw = 1'b1;
        push_exp(8'h77); stop_tx();
        n = 0;
        while (!(bus.awvalid && bus.awaddr == 4'h4) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("aw pending");
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst awvalid", {31'h0, bus.awvalid}, 0);
        check("midrst err", {31'h0, err}, 0);
        check("midrst level", {27'h0, tx_level}, 0);
        hold_aw = 1'b0;

`ifdef UART_RX_EN
        // received byte held until the consumer takes it
        reset_dut();
        rx_ready = 1'b0; rx_reg = 8'h5A; stat_val = 8'h01;
        n = 0;
        while (!rx_valid && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) timeout("rx first");
        check("rx data", {24'h0, rx_data}, 32'h5A);
        r0 = rx_reads;
        repeat (80) @(negedge clk);
        check("rx held", {31'h0, rx_valid}, 1);
        check("no second rx read", rx_reads - r0, 0);
        rx_reg = 8'h3C; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx cleared", {31'h0, rx_valid}, 0);
        n = 0;
        while (!rx_valid && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) timeout("rx second");
        check("rx data 2", {24'h0, rx_data}, 32'h3C);
        stat_val = 8'h04; rx_ready = 1'b1;
`endif

        check("wstrb/wdata upper", strb_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
